// File: rtl/async_fifo_gen.sv
// async_fifo_gen: parametrised dual-clock FIFO with Gray-coded pointer crossing,
// per-domain fill levels, almost-full/empty flags and sticky error flags.
`timescale 1ns/1ps
module async_fifo_gen #(
  parameter int DW = 36,
  parameter int AW = 9,
  parameter int AFULL_TH = 2**AW - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic          rclk,
  input  logic          dirclr_,
  input  logic          wclk,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  output logic          wfull,
  output logic          walmost_full,
  output logic [AW:0]   wlevel,
  output logic          woverflow,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rempty,
  output logic          ralmost_empty,
  output logic [AW:0]   rlevel,
  output logic          runderflow
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0] wbin, wgray, wbin_next, wgray_next, rq1, rq2;
  logic [AW:0] rbin, rgray, rbin_next, rgray_next, wq1, wq2;
  logic wpush, rpop;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign wpush = wen & ~wfull;
  assign wbin_next = wbin + (AW+1)'(wpush);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rpop = ren & ~rempty;
  assign rbin_next = rbin + (AW+1)'(rpop);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign walmost_full = wlevel >= (AW+1)'(AFULL_TH);
  assign ralmost_empty = rlevel <= (AW+1)'(AEMPTY_TH);

  always_ff @(posedge wclk) begin
    if (wpush) mem[wbin[AW-1:0]] <= wdata;
  end

  // Full when the write pointer has lapped the synchronised read pointer once.
  always_ff @(posedge wclk or posedge dirclr_) begin
    if (dirclr_) begin
      wbin <= '0;
      wgray <= '0;
      rq1 <= '0;
      rq2 <= '0;
      wfull <= 1'b0;
      wlevel <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wgray <= wgray_next;
      rq1 <= rgray;
      rq2 <= rq1;
      wfull <= wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]};
      wlevel <= wbin_next - gray2bin(rq2);
      woverflow <= woverflow | (wen & wfull);
    end
  end

  always_ff @(posedge rclk or posedge dirclr_) begin
    if (dirclr_) begin
      rbin <= '0;
      rgray <= '0;
      wq1 <= '0;
      wq2 <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      runderflow <= 1'b0;
    end else begin
      rbin <= rbin_next;
      rgray <= rgray_next;
      wq1 <= wgray;
      wq2 <= wq1;
      rempty <= rgray_next == wq2;
      rlevel <= gray2bin(wq2) - rbin_next;
      rdata <= rpop ? mem[rbin[AW-1:0]] : rdata;
      rvalid <= rpop;
      runderflow <= runderflow | (ren & rempty);
    end
  end
endmodule
